// File: rtl/l2_arbiter.sv
// Two-port arbiter sharing the unified L2 between the L1 I-cache and D-cache.
// One transaction at a time, round-robin on contention, one recovery cycle between grants.
module l2_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic                  icache_resp,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic                  dcache_resp,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  L2_read,
  output logic                  L2_write,
  output logic [ADDR_WIDTH-1:0] L2_address,
  output logic [LINE_WIDTH-1:0] L2_wdata,
  input  logic                  L2_resp,
  input  logic [LINE_WIDTH-1:0] L2_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t                state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_q, op_d;

  logic i_req;
  logic d_req;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    L2_read      = 1'b0;
    L2_write     = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        // D wins when alone, or on contention when I had the previous grant
        if (d_req && (!i_req || last_grant_q == GRANT_I)) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = dcache_address;
          wdata_d      = dcache_wdata;
          op_d         = dcache_write;
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = icache_address;
        end
      end
      SERVE_I: begin
        L2_read = 1'b1;
        if (L2_resp) begin
          icache_resp = 1'b1;
          state_d     = RECOVER;
        end
      end
      SERVE_D: begin
        L2_read  = ~op_q;
        L2_write = op_q;
        if (L2_resp) begin
          dcache_resp = 1'b1;
          state_d     = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign L2_address   = addr_q;
  assign L2_wdata     = wdata_q;
  assign icache_rdata = L2_rdata;
  assign dcache_rdata = L2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_l2_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic          icache_resp;
  logic [LW-1:0] icache_rdata;
  logic          dcache_read;
  logic          dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata;
  logic          dcache_resp;
  logic [LW-1:0] dcache_rdata;
  logic          L2_read;
  logic          L2_write;
  logic [AW-1:0] L2_address;
  logic [LW-1:0] L2_wdata;
  logic          L2_resp;
  logic [LW-1:0] L2_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the transaction currently owning L2 (if any)
  bit          m_busy;
  bit          m_is_d;
  bit          m_wr;
  bit          m_recover;
  bit          m_last_d;
  bit [AW-1:0] m_addr;
  bit [LW-1:0] m_wdata;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_resp    (dcache_resp),
    .dcache_rdata   (dcache_rdata),
    .L2_read        (L2_read),
    .L2_write       (L2_write),
    .L2_address     (L2_address),
    .L2_wdata       (L2_wdata),
    .L2_resp        (L2_resp),
    .L2_rdata       (L2_rdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    L2_resp        = 1'b0;
    L2_rdata       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Respond to whatever is being served, then idle everything through RECOVER
  task automatic finish_txn();
    L2_resp = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_wr = 0; m_recover = 0; m_last_d = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit ir;
    bit dr;
    bit take_d;
    ir = icache_read;
    dr = dcache_read | dcache_write;
    if (m_busy) begin
      if (L2_resp) begin
        m_busy    = 0;
        m_recover = 1;
      end
    end else if (m_recover) begin
      m_recover = 0;
    end else if (ir || dr) begin
      take_d   = dr && (!ir || !m_last_d);
      m_busy   = 1;
      m_is_d   = take_d;
      m_last_d = take_d;
      if (take_d) begin
        m_addr  = dcache_address;
        m_wdata = dcache_wdata;
        m_wr    = dcache_write;
      end else begin
        m_addr = icache_address;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write, icache_resp, dcache_resp} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {L2_read, L2_write, icache_resp, dcache_resp});
    else n_pass++;
    n_checks++;
    if (L2_address !== '0 || L2_wdata !== '0)
      $display("FAIL reset_regs: got addr %h wdata %h want 0", L2_address, L2_wdata);
    else n_pass++;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write} !== 2'b00)
      $display("FAIL reset_idle: got %b want 00", {L2_read, L2_write});
    else n_pass++;
  endtask

  task automatic test_icache_read();
    do_reset();
    icache_read    = 1'b1;
    icache_address = 16'h1230;
    @(negedge clk);
    n_checks++;
    if (L2_read !== 1'b0) $display("FAIL i_cycle0: got L2_read %b want 0", L2_read);
    else n_pass++;
    next_cycle();
    icache_address = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write} !== 2'b10 || L2_address !== 16'h1230)
      $display("FAIL i_cycle1: got rw %b addr %h want 10 1230", {L2_read, L2_write}, L2_address);
    else n_pass++;
    next_cycle();
    next_cycle();
    next_cycle();
    L2_resp  = 1'b1;
    L2_rdata = {16{8'hA5}};
    @(negedge clk);
    n_checks++;
    if ({icache_resp, dcache_resp} !== 2'b10 || icache_rdata !== {16{8'hA5}} || L2_address !== 16'h1230)
      $display("FAIL i_resp: got resp %b rdata %h addr %h want 10 a5.. 1230",
               {icache_resp, dcache_resp}, icache_rdata, L2_address);
    else n_pass++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write, icache_resp, dcache_resp} !== 4'b0000)
      $display("FAIL i_recover: got %b want 0000", {L2_read, L2_write, icache_resp, dcache_resp});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_dcache_write();
    do_reset();
    dcache_write   = 1'b1;
    dcache_address = 16'h4560;
    dcache_wdata   = {4{32'hDEADBEEF}};
    next_cycle();
    dcache_address = 16'h0BAD;
    dcache_wdata   = '1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({L2_read, L2_write, dcache_resp} !== 3'b010 || L2_address !== 16'h4560 ||
          L2_wdata !== {4{32'hDEADBEEF}})
        $display("FAIL d_hold%0d: got rw/resp %b addr %h wdata %h want 010 4560 deadbeef..",
                 i, {L2_read, L2_write, dcache_resp}, L2_address, L2_wdata);
      else n_pass++;
      next_cycle();
    end
    L2_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({icache_resp, dcache_resp} !== 2'b01)
      $display("FAIL d_resp: got %b want 01", {icache_resp, dcache_resp});
    else n_pass++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if ({L2_write, icache_resp, dcache_resp} !== 3'b000)
      $display("FAIL d_after: got %b want 000", {L2_write, icache_resp, dcache_resp});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] want;
    do_reset();
    icache_read    = 1'b1;
    icache_address = 16'h1111;
    dcache_read    = 1'b1;
    dcache_address = 16'h2222;
    for (int unsigned g = 0; g < 4; g++) begin
      want = (g % 2 == 0) ? 16'h2222 : 16'h1111;
      next_cycle();
      L2_resp = 1'b1;
      @(negedge clk);
      n_checks++;
      if (L2_read !== 1'b1 || L2_address !== want ||
          {icache_resp, dcache_resp} !== ((g % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL alt_grant%0d: got rd %b addr %h resp %b want addr %h",
                 g, L2_read, L2_address, {icache_resp, dcache_resp}, want);
      else n_pass++;
      next_cycle();
      L2_resp = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({L2_read, L2_write, icache_resp, dcache_resp} !== 4'b0000)
        $display("FAIL alt_recover%0d: got %b want 0000", g, {L2_read, L2_write, icache_resp, dcache_resp});
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_mid_service();
    do_reset();
    icache_read    = 1'b1;
    icache_address = 16'h0A00;
    dcache_address = 16'h0D00;
    next_cycle();
    dcache_read = 1'b1;
    next_cycle();
    L2_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({icache_resp, dcache_resp} !== 2'b10 || L2_address !== 16'h0A00)
      $display("FAIL mid_iresp: got resp %b addr %h want 10 0a00", {icache_resp, dcache_resp}, L2_address);
    else n_pass++;
    next_cycle();
    L2_resp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write} !== 2'b00)
      $display("FAIL mid_recover: got %b want 00", {L2_read, L2_write});
    else n_pass++;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (L2_read !== 1'b1 || L2_address !== 16'h0D00)
      $display("FAIL mid_dgrant: got rd %b addr %h want 1 0d00", L2_read, L2_address);
    else n_pass++;
    finish_txn();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dcache_write   = 1'b1;
    dcache_address = 16'h7770;
    dcache_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (L2_write !== 1'b1) $display("FAIL rst_pre: got L2_write %b want 1", L2_write);
    else n_pass++;
    #1;
    L2_resp = 1'b1;
    reset   = 1'b1;
    #1;
    n_checks++;
    if ({L2_read, L2_write, icache_resp, dcache_resp} !== 4'b0000)
      $display("FAIL rst_async: got %b want 0000", {L2_read, L2_write, icache_resp, dcache_resp});
    else n_pass++;
    next_cycle();
    reset          = 1'b0;
    L2_resp        = 1'b0;
    dcache_write   = 1'b0;
    dcache_read    = 1'b1;
    dcache_address = 16'h3330;
    icache_read    = 1'b1;
    icache_address = 16'h5550;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({L2_read, L2_write} !== 2'b10 || L2_address !== 16'h3330)
      $display("FAIL rst_regrant: got rw %b addr %h want 10 3330", {L2_read, L2_write}, L2_address);
    else n_pass++;
    finish_txn();
  endtask

  task automatic test_spurious_resp();
    do_reset();
    L2_resp = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({L2_read, L2_write, icache_resp, dcache_resp} !== 4'b0000)
        $display("FAIL spur%0d: got %b want 0000", i, {L2_read, L2_write, icache_resp, dcache_resp});
      else n_pass++;
      next_cycle();
    end
    L2_resp        = 1'b0;
    icache_read    = 1'b1;
    icache_address = 16'h0042;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (L2_read !== 1'b1 || L2_address !== 16'h0042)
      $display("FAIL spur_grant: got rd %b addr %h want 1 0042", L2_read, L2_address);
    else n_pass++;
    finish_txn();
  endtask

  task automatic test_random();
    bit exp_rd, exp_wr, exp_ir, exp_dr;
    do_reset();
    model_reset();
    for (int unsigned c = 0; c < 400; c++) begin
      icache_read    = ($urandom_range(0, 2) != 0);
      icache_address = 16'($urandom());
      dcache_read    = 1'($urandom_range(0, 1));
      dcache_write   = ($urandom_range(0, 3) == 0);
      dcache_address = 16'($urandom());
      dcache_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      L2_resp        = ($urandom_range(0, 2) == 0);
      L2_rdata       = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      exp_rd = m_busy && !(m_is_d && m_wr);
      exp_wr = m_busy && m_is_d && m_wr;
      exp_ir = m_busy && !m_is_d && L2_resp;
      exp_dr = m_busy && m_is_d && L2_resp;
      n_checks++;
      if ({L2_read, L2_write, icache_resp, dcache_resp} !== {exp_rd, exp_wr, exp_ir, exp_dr})
        $display("FAIL rand_ctrl c%0d: got %b want %b", c,
                 {L2_read, L2_write, icache_resp, dcache_resp}, {exp_rd, exp_wr, exp_ir, exp_dr});
      else n_pass++;
      n_checks++;
      if (L2_address !== m_addr || L2_wdata !== m_wdata)
        $display("FAIL rand_regs c%0d: got addr %h wdata %h want %h %h", c, L2_address, L2_wdata, m_addr, m_wdata);
      else n_pass++;
      n_checks++;
      if (icache_rdata !== L2_rdata || dcache_rdata !== L2_rdata)
        $display("FAIL rand_rdata c%0d: got %h %h want %h", c, icache_rdata, dcache_rdata, L2_rdata);
      else n_pass++;
      @(posedge clk);
      model_edge();
      #1;
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_back_to_back();
    test_mid_service();
    test_reset_mid();
    test_spurious_resp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
